// File: rtl/graph_pkg.sv
// Shared constants and FSM state type for the SSSP graph fetch logic.
// No ports. Used by graph_lane_mask and graph_edge_fetch.
package graph_pkg;

  localparam int LANES      = 16;     // 32-bit entries per 512-bit line
  localparam int LINE_BYTES = 64;
  localparam int PAGE_BYTES = 4096;   // AXI bursts may not cross this boundary
  localparam int PAGE_LINES = PAGE_BYTES / LINE_BYTES;

  localparam logic [2:0] AXI_SIZE_LINE  = 3'd6;  // 64-byte beats
  localparam logic [1:0] AXI_BURST_INCR = 2'd1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PTR_AR  = 3'd1,
    PTR_R   = 3'd2,
    EMPTY   = 3'd3,
    DATA_AR = 3'd4,
    DATA_R  = 3'd5,
    DONE    = 3'd6
  } fetch_state_t;

endpackage

// File: rtl/graph_lane_mask.sv
// Combinational lane mask for one 16-entry line.
// Ports:
//   line_idx    - line number (global entry index / 16)
//   range_start - first valid global entry index (inclusive)
//   range_end   - end of valid range (exclusive)
//   keep        - bit i set when entry line_idx*16+i lies in [range_start, range_end)
module graph_lane_mask
  import graph_pkg::*;
#(
  parameter int NODE_W = 32
) (
  input  logic [NODE_W-5:0]  line_idx,
  input  logic [NODE_W-1:0]  range_start,
  input  logic [NODE_W-1:0]  range_end,
  output logic [LANES-1:0]   keep
);

  always_comb begin
    keep = '0;
    for (int i = 0; i < LANES; i++) begin
      keep[i] = ({line_idx, 4'(i)} >= range_start) && ({line_idx, 4'(i)} < range_end);
    end
  end

endmodule

// File: rtl/graph_edge_fetch.sv
// Edge fetch stage: for each node ID, reads the CSR row pointers ptr[n] and
// ptr[n+1] over AXI, then streams the adjacency lines covering [ptr[n], ptr[n+1])
// as lane-masked beats with one io_edge_last per node.
// Ports:
//   clk, reset             - clock, asynchronous active-low reset
//   io_addr_ptr/_data      - 64 B aligned bases of row-pointer and edge arrays
//   io_node_*              - node ID request (valid/ready)
//   io_axi_ar* / io_axi_r* - AXI4 read master (single outstanding AR)
//   io_edge_*              - output beat stream: data, keep, last, source node
//   io_busy, io_cnt_node   - FSM not idle, completed node count
//   io_err                 - sticky: bad rresp or decreasing row pointers
//   io_dbg_state           - current FSM state (fetch_state_t encoding)
// Optional build macro GRAPH_FETCH_PERF_EN adds io_cnt_stall and io_cnt_beat.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high; valid never waits on ready, and once raised valid and its payload
// stay stable until that transfer.
module graph_edge_fetch
  import graph_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 512,
  parameter int NODE_W    = 32,
  parameter int MAX_BURST = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  io_addr_ptr,
  input  logic [ADDR_W-1:0]  io_addr_data,
  input  logic               io_node_valid,
  output logic               io_node_ready,
  input  logic [NODE_W-1:0]  io_node_data,
  output logic               io_axi_arvalid,
  input  logic               io_axi_arready,
  output logic [ADDR_W-1:0]  io_axi_araddr,
  output logic               io_axi_arid,
  output logic [7:0]         io_axi_arlen,
  output logic [2:0]         io_axi_arsize,
  output logic [1:0]         io_axi_arburst,
  input  logic               io_axi_rvalid,
  output logic               io_axi_rready,
  input  logic [DATA_W-1:0]  io_axi_rdata,
  input  logic               io_axi_rid,
  input  logic [1:0]         io_axi_rresp,
  input  logic               io_axi_rlast,
  output logic               io_edge_valid,
  input  logic               io_edge_ready,
  output logic [DATA_W-1:0]  io_edge_data,
  output logic [LANES-1:0]   io_edge_keep,
  output logic               io_edge_last,
  output logic [NODE_W-1:0]  io_edge_src,
  output logic               io_busy,
  output logic [31:0]        io_cnt_node,
  output logic               io_err,
`ifdef GRAPH_FETCH_PERF_EN
  output logic [31:0]        io_cnt_stall,
  output logic [31:0]        io_cnt_beat,
`endif
  output logic [2:0]         io_dbg_state
);

  localparam int LINE_W = NODE_W - 4;

  fetch_state_t       state;
  logic [NODE_W-1:0]  ptr_start, ptr_end;
  logic               ptr_beat;    // second pointer beat (split row) in progress
  logic [LINE_W-1:0]  beat_line;   // line index of the next data beat
  logic [LINE_W-1:0]  last_line;   // line holding entry end-1
  logic               drain;       // all data received, waiting for last beat to leave

  assign io_axi_arid    = 1'b0;
  assign io_axi_arsize  = AXI_SIZE_LINE;
  assign io_axi_arburst = AXI_BURST_INCR;
  assign io_busy        = (state != IDLE);
  assign io_dbg_state   = state;

  logic r_hs, out_free;
  assign out_free      = !io_edge_valid || io_edge_ready;
  assign io_axi_rready = (state == PTR_R) || ((state == DATA_R) && !drain && out_free);
  assign r_hs          = io_axi_rvalid && io_axi_rready;

  // Row pointer extraction: ptr[n] sits in lane n[3:0] of beat 0; ptr[n+1] is the
  // next lane, or lane 0 of beat 1 when n[3:0]==15.
  logic [3:0]        ln, ln_nx;
  logic [NODE_W-1:0] r_lo, r_nx, r_l0, s_now, e_now, e_m1;
  assign ln    = io_edge_src[3:0];
  assign ln_nx = ln + 4'd1;
  assign r_lo  = io_axi_rdata[int'(ln)*NODE_W +: NODE_W];
  assign r_nx  = io_axi_rdata[int'(ln_nx)*NODE_W +: NODE_W];
  assign r_l0  = io_axi_rdata[NODE_W-1:0];
  assign s_now = ptr_beat ? ptr_start : r_lo;
  assign e_now = ptr_beat ? r_l0 : ((ln == 4'hF) ? ptr_end : r_nx);
  assign e_m1  = e_now - NODE_W'(1);

  logic [ADDR_W-1:0] ptr_addr;
  assign ptr_addr = io_addr_ptr + ADDR_W'({io_node_data, 2'b00});

  // Next data burst: first line either from the pointers just read or the line
  // after the current burst; length capped by lines left, MAX_BURST and the page.
  logic [LINE_W-1:0] dar_line, dar_last, dar_beats;
  logic [ADDR_W-1:0] dar_addr;
  logic [6:0]        dar_page;
  logic [7:0]        dar_len;
  always_comb begin
    dar_line  = (state == PTR_R) ? s_now[NODE_W-1:4] : beat_line + LINE_W'(1);
    dar_last  = (state == PTR_R) ? e_m1[NODE_W-1:4]  : last_line;
    dar_addr  = io_addr_data + ADDR_W'({dar_line, 6'b0});
    dar_page  = 7'(PAGE_LINES) - {1'b0, dar_addr[11:6]};
    dar_beats = dar_last - dar_line + LINE_W'(1);
    if (dar_beats > LINE_W'(MAX_BURST)) dar_beats = LINE_W'(MAX_BURST);
    if (dar_beats > LINE_W'(dar_page))  dar_beats = LINE_W'(dar_page);
    dar_len   = 8'(dar_beats - LINE_W'(1));
  end

  logic [LANES-1:0] line_keep;
  graph_lane_mask #(.NODE_W(NODE_W)) u_mask (
    .line_idx    (beat_line),
    .range_start (ptr_start),
    .range_end   (ptr_end),
    .keep        (line_keep)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      io_node_ready  <= 1'b0;
      io_axi_arvalid <= 1'b0;
      io_axi_araddr  <= '0;
      io_axi_arlen   <= '0;
      io_edge_valid  <= 1'b0;
      io_edge_data   <= '0;
      io_edge_keep   <= '0;
      io_edge_last   <= 1'b0;
      io_edge_src    <= '0;
      io_cnt_node    <= '0;
      io_err         <= 1'b0;
      ptr_start      <= '0;
      ptr_end        <= '0;
      ptr_beat       <= 1'b0;
      beat_line      <= '0;
      last_line      <= '0;
      drain          <= 1'b0;
    end else begin
      if (io_edge_valid && io_edge_ready) io_edge_valid <= 1'b0;
      if (r_hs && (io_axi_rresp != 2'b00)) io_err <= 1'b1;

      case (state)
        IDLE: begin
          if (io_node_ready && io_node_valid) begin
            io_node_ready  <= 1'b0;
            io_edge_src    <= io_node_data;
            io_axi_arvalid <= 1'b1;
            io_axi_araddr  <= {ptr_addr[ADDR_W-1:6], 6'b0};
            io_axi_arlen   <= (io_node_data[3:0] == 4'hF) ? 8'd1 : 8'd0;
            ptr_beat       <= 1'b0;
            state          <= PTR_AR;
          end else begin
            io_node_ready  <= 1'b1;
          end
        end
        PTR_AR: begin
          if (io_axi_arready) begin
            io_axi_arvalid <= 1'b0;
            state          <= PTR_R;
          end
        end
        PTR_R: begin
          if (r_hs) begin
            ptr_beat  <= 1'b1;
            ptr_start <= s_now;
            ptr_end   <= e_now;
            if (io_axi_rlast) begin
              last_line <= e_m1[NODE_W-1:4];
              if (e_now > s_now) begin
                beat_line      <= s_now[NODE_W-1:4];
                io_axi_arvalid <= 1'b1;
                io_axi_araddr  <= {dar_addr[ADDR_W-1:6], 6'b0};
                io_axi_arlen   <= dar_len;
                state          <= DATA_AR;
              end else begin
                // No edges: a single empty beat still closes the node.
                io_edge_valid <= 1'b1;
                io_edge_data  <= '0;
                io_edge_keep  <= '0;
                io_edge_last  <= 1'b1;
                if (e_now < s_now) io_err <= 1'b1;
                state         <= EMPTY;
              end
            end
          end
        end
        EMPTY: begin
          if (io_edge_valid && io_edge_ready) state <= DONE;
        end
        DATA_AR: begin
          if (io_axi_arready) begin
            io_axi_arvalid <= 1'b0;
            drain          <= 1'b0;
            state          <= DATA_R;
          end
        end
        DATA_R: begin
          if (drain) begin
            if (out_free) state <= DONE;
          end else if (r_hs) begin
            io_edge_valid <= 1'b1;
            io_edge_data  <= io_axi_rdata;
            io_edge_keep  <= line_keep;
            io_edge_last  <= (beat_line == last_line);
            beat_line     <= beat_line + LINE_W'(1);
            if (io_axi_rlast) begin
              if (beat_line != last_line) begin
                io_axi_arvalid <= 1'b1;
                io_axi_araddr  <= {dar_addr[ADDR_W-1:6], 6'b0};
                io_axi_arlen   <= dar_len;
                state          <= DATA_AR;
              end else begin
                drain <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          io_cnt_node   <= io_cnt_node + 32'd1;
          io_node_ready <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GRAPH_FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      io_cnt_stall <= '0;
      io_cnt_beat  <= '0;
    end else begin
      if (io_edge_valid && !io_edge_ready) io_cnt_stall <= io_cnt_stall + 32'd1;
      if ((state == DATA_R) && r_hs)       io_cnt_beat  <= io_cnt_beat + 32'd1;
    end
  end
`endif

  logic unused_bits;
  assign unused_bits = &{1'b0, io_axi_rid, e_m1[3:0], ptr_addr[5:0], dar_addr[5:0]};

endmodule

// File: tb/tb_graph_edge_fetch.sv
// Testbench for graph_edge_fetch: AXI read slave backed by a memory model,
// randomized ready/valid pacing, and a reference model that derives expected
// AR requests and output beats from the CSR arrays.
module tb_graph_edge_fetch;
  import graph_pkg::*;

  localparam logic [63:0] PTR_BASE = 64'h1000_0000;
  localparam int BW = 32 + 1 + 16 + 512;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [63:0]  io_addr_ptr, io_addr_data;
  logic         io_node_valid, io_node_ready;
  logic [31:0]  io_node_data;
  logic         io_axi_arvalid, io_axi_arready, io_axi_arid;
  logic [63:0]  io_axi_araddr;
  logic [7:0]   io_axi_arlen;
  logic [2:0]   io_axi_arsize;
  logic [1:0]   io_axi_arburst;
  logic         io_axi_rvalid, io_axi_rready, io_axi_rid, io_axi_rlast;
  logic [511:0] io_axi_rdata;
  logic [1:0]   io_axi_rresp;
  logic         io_edge_valid, io_edge_ready, io_edge_last;
  logic [511:0] io_edge_data;
  logic [15:0]  io_edge_keep;
  logic [31:0]  io_edge_src;
  logic         io_busy, io_err;
  logic [31:0]  io_cnt_node;
  logic [2:0]   io_dbg_state;
`ifdef GRAPH_FETCH_PERF_EN
  logic [31:0]  io_cnt_stall, io_cnt_beat;
`endif

  graph_edge_fetch dut (
    .clk(clk), .reset(reset),
    .io_addr_ptr(io_addr_ptr), .io_addr_data(io_addr_data),
    .io_node_valid(io_node_valid), .io_node_ready(io_node_ready), .io_node_data(io_node_data),
    .io_axi_arvalid(io_axi_arvalid), .io_axi_arready(io_axi_arready), .io_axi_araddr(io_axi_araddr),
    .io_axi_arid(io_axi_arid), .io_axi_arlen(io_axi_arlen), .io_axi_arsize(io_axi_arsize),
    .io_axi_arburst(io_axi_arburst),
    .io_axi_rvalid(io_axi_rvalid), .io_axi_rready(io_axi_rready), .io_axi_rdata(io_axi_rdata),
    .io_axi_rid(io_axi_rid), .io_axi_rresp(io_axi_rresp), .io_axi_rlast(io_axi_rlast),
    .io_edge_valid(io_edge_valid), .io_edge_ready(io_edge_ready), .io_edge_data(io_edge_data),
    .io_edge_keep(io_edge_keep), .io_edge_last(io_edge_last), .io_edge_src(io_edge_src),
    .io_busy(io_busy), .io_cnt_node(io_cnt_node), .io_err(io_err),
`ifdef GRAPH_FETCH_PERF_EN
    .io_cnt_stall(io_cnt_stall), .io_cnt_beat(io_cnt_beat),
`endif
    .io_dbg_state(io_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [71:0]   exp_ar_q[$];    // {araddr, arlen}
  logic [BW-1:0] exp_beat_q[$];  // {src, last, keep, data}
  int   exp_cnt = 0;
  logic exp_err = 1'b0;

  task automatic check_eq(input string tag, input logic [575:0] got, input logic [575:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [63:0] data_base;
  logic [31:0] ptr_mem [int];

  function automatic logic [31:0] ptr_word(input int n);
    return ptr_mem.exists(n) ? ptr_mem[n] : 32'd0;
  endfunction

  function automatic logic [31:0] edge_word(input longint idx);
    return 32'(idx) * 32'h9E37_79B1 + 32'h0BAD_F00D;
  endfunction

  function automatic logic [511:0] mem_line(input logic [63:0] addr);
    logic [511:0] v;
    logic [63:0]  a;
    for (int i = 0; i < 16; i++) begin
      a = addr + 64'(4 * i);
      if (a >= data_base) v[32*i +: 32] = edge_word(longint'((a - data_base) >> 2));
      else                v[32*i +: 32] = ptr_word(int'((a - PTR_BASE) >> 2));
    end
    return v;
  endfunction

  // Reference: which requests and beats a node must produce.
  task automatic model_node(input int n);
    longint s, e, first, lst, line, b, pg;
    logic [63:0] a;
    logic [15:0] kp;
    s = longint'(ptr_word(n));
    e = longint'(ptr_word(n + 1));
    exp_ar_q.push_back({(PTR_BASE + 64'(4 * n)) & ~64'd63, (n % 16 == 15) ? 8'd1 : 8'd0});
    if (e > s) begin
      first = s / 16;
      lst   = (e - 1) / 16;
      line  = first;
      while (line <= lst) begin
        a  = data_base + 64'(line * 64);
        pg = (4096 - longint'(a % 4096)) / 64;
        b  = lst - line + 1;
        if (b > 64) b = 64;
        if (b > pg) b = pg;
        exp_ar_q.push_back({a, 8'(b - 1)});
        line += b;
      end
      for (longint l = first; l <= lst; l++) begin
        for (int i = 0; i < 16; i++) kp[i] = ((l * 16 + i) >= s) && ((l * 16 + i) < e);
        exp_beat_q.push_back({32'(n), (l == lst), kp, mem_line(data_base + 64'(l * 64))});
      end
    end else begin
      exp_beat_q.push_back({32'(n), 1'b1, 16'h0, 512'h0});
      if (e < s) exp_err = 1'b1;
    end
    exp_cnt++;
  endtask

  // ---------------- AXI read slave ----------------
  int   r_prob = 100;
  bit   inject_rresp = 0;
  bit   sl_busy = 0, sl_ptr = 0, prev_data_hs = 0;
  int   sl_left = 0;
  logic [63:0] sl_addr, ar_addr_s;
  logic [7:0]  ar_len_s;
  logic        ar_hs, r_hs;

  initial begin
    io_axi_arready = 1'b0;
    io_axi_rvalid  = 1'b0;
    io_axi_rdata   = '0;
    io_axi_rid     = 1'b0;
    io_axi_rresp   = 2'b00;
    io_axi_rlast   = 1'b0;
    forever begin
      @(negedge clk);
      ar_hs     = io_axi_arvalid && io_axi_arready;
      r_hs      = io_axi_rvalid && io_axi_rready;
      ar_addr_s = io_axi_araddr;
      ar_len_s  = io_axi_arlen;
      if (reset) begin
        if (prev_data_hs) check_eq("r_to_edge_lat", io_edge_valid, 1'b1);
        if (ar_hs) begin
          if (exp_ar_q.size() == 0) check_eq("ar_unexpected", 1'b1, 1'b0);
          else check_eq("ar_addr_len", {ar_addr_s, ar_len_s}, exp_ar_q.pop_front());
          check_eq("ar_fixed", {io_axi_arid, io_axi_arsize, io_axi_arburst}, {1'b0, 3'd6, 2'd1});
        end
      end
      prev_data_hs = reset && r_hs && !sl_ptr;
      @(posedge clk);
      #1;
      if (!reset) begin
        sl_busy = 0; sl_left = 0; inject_rresp = 0; prev_data_hs = 0;
        io_axi_arready = 1'b0;
        io_axi_rvalid  = 1'b0;
        continue;
      end
      if (r_hs) begin
        sl_addr += 64;
        sl_left--;
        if (sl_left == 0) sl_busy = 0;
        io_axi_rvalid = 1'b0;
      end
      if (ar_hs) begin
        sl_busy = 1;
        sl_addr = ar_addr_s;
        sl_left = int'(ar_len_s) + 1;
        sl_ptr  = (ar_addr_s < data_base);
      end
      io_axi_arready = 1'($urandom_range(0, 1));
      if (sl_busy && !io_axi_rvalid && ($urandom_range(0, 99) < r_prob)) begin
        io_axi_rvalid = 1'b1;
        io_axi_rdata  = mem_line(sl_addr);
        io_axi_rlast  = (sl_left == 1);
        io_axi_rresp  = 2'b00;
        if (inject_rresp && !sl_ptr) begin
          io_axi_rresp = 2'b10;
          inject_rresp = 0;
        end
      end
    end
  end

  // ---------------- edge consumer / beat scoreboard ----------------
  int ready_mode = 0;  // 0: always ready, 1: random, 2: ready one cycle in three
  int cyc = 0;
  logic [BW-1:0] exp_b;

  initial begin
    io_edge_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (io_edge_valid && !io_edge_ready) check_eq("rready_stall", io_axi_rready, 1'b0);
        if (io_edge_valid && io_edge_ready) begin
          if (exp_beat_q.size() == 0) check_eq("beat_unexpected", 1'b1, 1'b0);
          else begin
            exp_b = exp_beat_q.pop_front();
            check_eq("beat_ctl", {io_edge_src, io_edge_last, io_edge_keep}, exp_b[BW-1:512]);
            if (exp_b[527:512] != 16'h0) check_eq("beat_data", io_edge_data, exp_b[511:0]);
          end
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      case (ready_mode)
        0:       io_edge_ready = 1'b1;
        1:       io_edge_ready = 1'($urandom_range(0, 1));
        default: io_edge_ready = (cyc % 3 == 0);
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_node(input int n);
    bit acc = 0;
    @(posedge clk);
    #1;
    io_node_data  = 32'(n);
    io_node_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (io_node_ready) begin acc = 1; break; end
    end
    @(posedge clk);
    #1;
    io_node_valid = 1'b0;
    check_eq("node_accept", acc, 1'b1);
    @(negedge clk);
    if (acc) check_eq("ptr_ar_lat", io_axi_arvalid, 1'b1);
  endtask

  task automatic wait_done();
    bit done = 0;
    for (int t = 0; t < 20000; t++) begin
      @(negedge clk);
      if (!io_busy && exp_beat_q.size() == 0 && exp_ar_q.size() == 0) begin done = 1; break; end
    end
    check_eq("node_done", done, 1'b1);
    check_eq("cnt_node", io_cnt_node, exp_cnt);
    check_eq("err", io_err, exp_err);
  endtask

  task automatic run_node(input int n);
    model_node(n);
    send_node(n);
    wait_done();
  endtask

  task automatic set_ptr(input int n, input int s, input int e);
    ptr_mem[n]     = 32'(s);
    ptr_mem[n + 1] = 32'(e);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, s, e, k;
    bit ok;
    reset         = 1'b0;
    io_addr_ptr   = PTR_BASE;
    data_base     = 64'h2000_0000;
    io_addr_data  = data_base;
    io_node_valid = 1'b0;
    io_node_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_node_ready", io_node_ready, 1'b0);
    check_eq("rst_valids", {io_edge_valid, io_axi_arvalid, io_axi_rready}, 3'b000);
    check_eq("rst_busy", io_busy, 1'b0);
    check_eq("rst_cnt", io_cnt_node, 32'd0);
    check_eq("rst_err", io_err, 1'b0);
    check_eq("rst_state", io_dbg_state, 3'(IDLE));
    @(posedge clk);
    #3;
    reset = 1'b1;

    // Short row inside one line.
    set_ptr(3, 20, 25);
    run_node(3);
    // Row pointer pair split across two lines.
    set_ptr(15, 0, 40);
    run_node(15);
    // Degree zero.
    set_ptr(5, 7, 7);
    run_node(5);
    // 76 lines from a page-aligned base: MAX_BURST split.
    set_ptr(7, 0, 1201);
    run_node(7);
    // Same 10-line node with and without downstream stalls.
    ready_mode = 2;
    set_ptr(9, 5, 158);
    run_node(9);
    ready_mode = 0;
    run_node(9);
    // Error response on a data beat; flag stays through the next node.
    set_ptr(20, 30, 70);
    inject_rresp = 1;
    exp_err = 1'b1;
    run_node(20);
    run_node(3);

    // Reset in the middle of a data fetch.
    ready_mode = 1;
    set_ptr(30, 0, 600);
    model_node(30);
    send_node(30);
    ok = 0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (io_dbg_state == 3'(DATA_R)) begin ok = 1; break; end
    end
    check_eq("reach_data_r", ok, 1'b1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_eq("mid_rst_valids", {io_edge_valid, io_axi_arvalid, io_axi_rready, io_node_ready}, 4'b0000);
    check_eq("mid_rst_busy_err", {io_busy, io_err}, 2'b00);
    check_eq("mid_rst_cnt", io_cnt_node, 32'd0);
    exp_ar_q.delete();
    exp_beat_q.delete();
    exp_cnt = 0;
    exp_err = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;

    // Random nodes, bases, degrees and pacing.
    for (int it = 0; it < 60; it++) begin
      ready_mode   = $urandom_range(0, 2);
      r_prob       = $urandom_range(30, 100);
      data_base    = 64'h2000_0000 + 64'(64 * $urandom_range(0, 63));
      io_addr_data = data_base;
      n = $urandom_range(0, 300);
      s = $urandom_range(1, 3000);
      k = $urandom_range(0, 9);
      if (k == 0)      e = s;
      else if (k == 1) e = s - $urandom_range(1, s);
      else if (k == 2) e = s + $urandom_range(700, 1500);
      else             e = s + $urandom_range(1, 200);
      set_ptr(n, s, e);
      if (e > s && $urandom_range(0, 9) == 0) begin
        inject_rresp = 1;
        exp_err = 1'b1;
      end
      run_node(n);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/graph_edge_fetch.md
Name: graph_edge_fetch

Overview:
- Upstream stage of the SSSP core: for each node ID popped from the frontier, fetches the node's CSR row pointers and streams its adjacency (edge) lines to the relaxation logic.
- Owns one AXI4 read-only master port (512-bit), sharing the core's AXI read channel via the arbiter.
- Output is a lane-masked beat stream with one `last` per node.

Parameters:
- ADDR_W, 64, AXI address width
- DATA_W, 512, AXI data width (16 lanes of 32-bit entries)
- NODE_W, 32, node ID / pointer width
- MAX_BURST, 64, maximum beats per AR burst (also the 4 KB boundary limit)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset (0 = in reset)
- io_addr_ptr  in  64  byte base of the row-pointer array (64 B aligned)
- io_addr_data  in  64  byte base of the edge array (64 B aligned)
- io_node_valid / io_node_ready  in/out  1  node request handshake
- io_node_data  in  32  node ID
- io_axi_ar{valid,ready,addr,id,len,size,burst}  out/in/out…  1/1/64/1/8/3/2  AXI AR channel
- io_axi_r{valid,ready,data,id,resp,last}  in/out/in…  1/1/512/1/2/1  AXI R channel
- io_edge_valid / io_edge_ready  out/in  1  edge stream handshake
- io_edge_data  out  512  raw data line
- io_edge_keep  out  16  lane valid mask (bit i = bits 32i+31:32i)
- io_edge_last  out  1  final beat for this node
- io_edge_src  out  32  node ID the beat belongs to
- io_busy  out  1  FSM not IDLE
- io_cnt_node  out  32  nodes completed
- io_err  out  1  sticky error flag

Behaviour:
- Reset values: all valids 0; io_node_ready 0; io_busy 0; counters 0; io_err 0; FSM = IDLE.
- Fixed AXI fields: arid=0, arsize=6, arburst=INCR; exactly one AR outstanding.
- io_node_ready=1 only in IDLE. A node accepted in IDLE latches n into src and moves to PTR_AR next cycle.
- PTR_AR:
  - araddr = (io_addr_ptr + 4n) & ~63.
  - arlen = 1 if n[3:0]==15 (ptr[n+1] in the next line), else 0.
  - Hold arvalid until arready.
- PTR_R:
  - rready=1; capture beats.
  - start = ptr[n] (lane n[3:0] of beat 0).
  - end = ptr[n+1] (lane n[3:0]+1 of beat 0, or lane 0 of beat 1 on a split).
  - On rlast:
    - end>start → DATA_AR.
    - end==start → EMPTY.
    - end<start → EMPTY and set io_err.
- EMPTY: emit one beat with keep=0, last=1; when accepted, go to DONE.
- DATA_AR:
  - line address a = io_addr_data + 4·cur, aligned down to 64 B (cur initialised to start).
  - beats = min(lines remaining to cover [cur,end), MAX_BURST, lines to next 4 KB boundary).
  - arlen = beats−1.
- DATA_R:
  - Each R beat goes into a 1-entry output register; rready = !io_edge_valid || io_edge_ready.
  - keep lane i set iff the lane's global index lies in [start,end).
  - last=1 on the beat containing index end−1.
  - On rlast of a burst: cur advances to the next unfetched line → DATA_AR if cur<end, else DONE once the last beat is accepted.
- DONE: io_cnt_node += 1 (wraps at 2^32), return to IDLE; the next node can be accepted the following cycle.
- Any rresp≠0 sets io_err (sticky until reset); data is still forwarded; the FSM does not abort.
- Backpressure: io_edge_ready low stalls R (rready=0); data and keep are never dropped or duplicated.
- Reset asserted mid-operation: FSM, output register and counters clear immediately. Outstanding AXI beats are not tracked; the system resets the interconnect together with this block.
- Latency: node accept → PTR araddr valid is 1 cycle; an R beat reaches io_edge_valid 1 cycle after its handshake.

Optional Feature:
- Macro GRAPH_FETCH_PERF_EN.
- Defined: adds outputs io_cnt_stall (32-bit, counts cycles with io_edge_valid && !io_edge_ready) and io_cnt_beat (32-bit, counts accepted data-R beats); both reset to 0 and wrap.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package graph_pkg:
  - LANES=16, LINE_BYTES=64, AXI_SIZE_LINE=3'd6, AXI_BURST_INCR=2'd1
  - FSM state enum (IDLE, PTR_AR, PTR_R, EMPTY, DATA_AR, DATA_R, DONE)
  - 4 KB page constant
- Sub-module graph_lane_mask (combinational): inputs line index, start, end; output 16-bit keep. Reused later by the frontier writer.

Test Plan:
- Node 3, ptr[3]=20, ptr[4]=25 → PTR araddr=base, arlen=0; DATA araddr=data+64, arlen=0; one beat keep=0x01F0, last=1, src=3; io_cnt_node=1.
- Node 15 (ptr split across lines), ptr=[.., 0, 40] → PTR arlen=1; DATA arlen=2 (3 lines); keeps 0xFFFF, 0xFFFF, 0x00FF; last on the 3rd beat.
- Degree 0 (ptr[n]==ptr[n+1]=7) → no DATA AR; one beat keep=0, last=1.
- Edge range 0..1200 with data base 4 KB aligned → bursts split as arlen=63 then arlen=11; 76 beats total, no dropped lanes.
- io_edge_ready toggled 1-of-3 cycles during a 10-beat fetch → rready mirrors the stall; output beat sequence identical to the no-stall run.
- rresp=2 on a data beat → io_err=1 and stays 1; node still completes. Assert reset mid-DATA_R → all outputs at reset values the same cycle.
